// File: rtl/core_arbiter.sv
// N-master to 1-slave core-bus arbiter: round-robin grant, selection locked while the slave
// stalls, and an in-order ID FIFO that routes each response back to its issuing master.
module core_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MAX_OUT   = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_MASTERS-1:0]            m_req,
  output logic [N_MASTERS-1:0]            m_gnt,
  input  logic [N_MASTERS-1:0]            m_we,
  input  logic [N_MASTERS*(DW/8)-1:0]     m_be,
  input  logic [N_MASTERS*AW-1:0]         m_addr,
  input  logic [N_MASTERS*DW-1:0]         m_wdata,
  output logic [N_MASTERS-1:0]            m_rvalid,
  output logic [DW-1:0]                   m_rdata,
  output logic [N_MASTERS-1:0]            m_err,
  output logic                            s_req,
  input  logic                            s_gnt,
  output logic                            s_we,
  output logic [DW/8-1:0]                 s_be,
  output logic [AW-1:0]                   s_addr,
  output logic [DW-1:0]                   s_wdata,
  input  logic                            s_rvalid,
  input  logic [DW-1:0]                   s_rdata,
  input  logic                            s_err,
  output logic                            proto_err
);

  localparam int BW = DW / 8;
  localparam int IW = $clog2(N_MASTERS);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          lock_vld_q, lock_vld_d;
  logic [IW-1:0] lock_id_q, lock_id_d;
  logic [IW-1:0] fifo_q [MAX_OUT];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          proto_err_q, proto_err_d;

  logic [IW-1:0] sel;
  logic [IW:0]   cand;
  logic          found;
  logic          full;
  logic          push;
  logic          pop;
  logic [IW-1:0] head;

  // Round-robin search starting at rr_ptr; a stalled request keeps its locked master.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sel   = rr_ptr_q;
    cand  = '0;
    found = 1'b0;
    if (lock_vld_q) begin
      sel = lock_id_q;
    end else begin
      for (int i = 0; i < N_MASTERS; i++) begin
        cand = {1'b0, rr_ptr_q} + (IW+1)'(i);
        if (cand >= (IW+1)'(N_MASTERS)) cand = cand - (IW+1)'(N_MASTERS);
        if (!found && m_req[cand[IW-1:0]]) begin
          sel   = cand[IW-1:0];
          found = 1'b1;
        end
      end
    end
  end

  assign full    = (count_q == CW'(MAX_OUT));
  assign s_req   = rst_n & (lock_vld_q | (|m_req)) & ~full;
  assign push    = s_req & s_gnt;
  assign pop     = rst_n & s_rvalid & (count_q != '0);
  assign head    = fifo_q[rd_ptr_q];

  assign s_we    = m_we[sel];
  assign s_be    = m_be[int'(sel)*BW +: BW];
  assign s_addr  = m_addr[int'(sel)*AW +: AW];
  assign s_wdata = m_wdata[int'(sel)*DW +: DW];
  assign m_rdata = s_rdata;
  assign proto_err = proto_err_q;

  always_comb begin
    m_gnt    = '0;
    m_rvalid = '0;
    m_err    = '0;
    if (push) m_gnt[sel] = 1'b1;
    if (pop) begin
      m_rvalid[head] = 1'b1;
      m_err[head]    = s_err;
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    lock_vld_d  = lock_vld_q;
    lock_id_d   = lock_id_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    proto_err_d = proto_err_q | (s_rvalid & (count_q == '0));
    if (push) begin
      rr_ptr_d   = (sel == IW'(N_MASTERS - 1)) ? '0 : sel + IW'(1);
      lock_vld_d = 1'b0;
      wr_ptr_d   = (wr_ptr_q == PW'(MAX_OUT - 1)) ? '0 : wr_ptr_q + PW'(1);
    end else if (s_req) begin
      lock_vld_d = 1'b1;
      lock_id_d  = sel;
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PW'(MAX_OUT - 1)) ? '0 : rd_ptr_q + PW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      lock_vld_q  <= 1'b0;
      lock_id_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
      // NOTE: the ID storage is small and must read as 0 after reset, so it is reset like any flop.
      for (int i = 0; i < MAX_OUT; i++) fifo_q[i] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_vld_q  <= lock_vld_d;
      lock_id_q   <= lock_id_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
      if (push) fifo_q[wr_ptr_q] <= sel;
    end
  end

endmodule
